// File: rtl/cluster_inject_arbiter_if.sv
// Cluster <-> router handshake bundle: PE injection requests, router injection port,
// and router ejection fan-out back to the PEs.
interface cluster_inject_arbiter_if #(
  parameter int CLUSTER_SIZE = 4,
  parameter int D_W          = 32,
  parameter int PKT_W        = 38
);
  logic [CLUSTER_SIZE-1:0]       pe_req;
  logic [CLUSTER_SIZE*PKT_W-1:0] pe_pkt;
  logic [CLUSTER_SIZE-1:0]       pe_ack;
  logic                          rtr_vld;
  logic [PKT_W-1:0]              rtr_pkt;
  logic                          rtr_ack;
  logic                          rtr_out_v;
  logic [PKT_W-1:0]              rtr_out_pkt;
  logic [CLUSTER_SIZE-1:0]       pe_in_vld;
  logic [D_W-1:0]                pe_in_payload;

  // arbiter side
  modport master (
    input  pe_req, pe_pkt, rtr_ack, rtr_out_v, rtr_out_pkt,
    output pe_ack, rtr_vld, rtr_pkt, pe_in_vld, pe_in_payload
  );

  // PE array / router side
  modport slave (
    output pe_req, pe_pkt, rtr_ack, rtr_out_v, rtr_out_pkt,
    input  pe_ack, rtr_vld, rtr_pkt, pe_in_vld, pe_in_payload
  );
endinterface

// File: rtl/cluster_inject_arbiter.sv
// Shares one router injection port among CLUSTER_SIZE PEs (round-robin into a
// single-entry holding register) and steers ejected packets to a PE by cluster ID.
module cluster_inject_arbiter #(
  parameter int CLUSTER_SIZE = 4,
  parameter int D_W          = 32,
  parameter int X_W          = 2,
  parameter int Y_W          = 2,
  parameter int C_W          = 2,
  parameter int PKT_W        = D_W + C_W + Y_W + X_W,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [CLUSTER_SIZE-1:0] pe_done,
  output logic [CNT_W-1:0]        inj_count,
  output logic                    drop_err,
  output logic                    done,
  cluster_inject_arbiter_if.master bus
);
  localparam int PTR_W = (CLUSTER_SIZE > 1) ? $clog2(CLUSTER_SIZE) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_e;

  hold_state_e                         state, state_nxt;
  logic                                hold_v;
  logic [PKT_W-1:0]                    hold_pkt;
  logic [PTR_W-1:0]                    rr_ptr, rr_nxt, gnt_idx;
  logic                                gnt_v, space, load;
  logic [CLUSTER_SIZE-1:0][PKT_W-1:0]  pe_pkt_a;
  logic [C_W-1:0]                      cid;
  logic                                cid_ok;
  logic                                unused_addr;

  assign pe_pkt_a    = bus.pe_pkt;
  assign hold_v      = (state == FULL);
  assign bus.rtr_vld = hold_v;
  assign bus.rtr_pkt = hold_pkt;
  assign done        = (&pe_done) & ~hold_v;

  // Round-robin search starting at rr_ptr, wrapping modulo CLUSTER_SIZE.
  always_comb begin
    int k;
    k       = 0;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < CLUSTER_SIZE; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= CLUSTER_SIZE) k = k - CLUSTER_SIZE;
      if (!gnt_v && bus.pe_req[k]) begin
        gnt_v   = 1'b1;
        gnt_idx = PTR_W'(k);
      end
    end
  end

  assign rr_nxt = (int'(gnt_idx) + 1 >= CLUSTER_SIZE) ? '0 : gnt_idx + PTR_W'(1);

  // Holding-register FSM; no grant may be issued while reset is asserted.
  always_comb begin
    state_nxt = state;
    space     = ce & (~hold_v | bus.rtr_ack);
    load      = space & gnt_v & ~rst;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (ce && bus.rtr_ack && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
    bus.pe_ack = '0;
    if (load) bus.pe_ack = CLUSTER_SIZE'(1) << gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= EMPTY;
    else if (ce) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_pkt  <= '0;
      rr_ptr    <= '0;
      inj_count <= '0;
    end else if (ce) begin
      if (load) begin
        hold_pkt <= pe_pkt_a[gnt_idx];
        rr_ptr   <= rr_nxt;
      end
      if (hold_v && bus.rtr_ack && inj_count != '1)
        inj_count <= inj_count + CNT_W'(1);
    end
  end

  // Ejection: never back-pressured; out-of-range cluster IDs are dropped and flagged.
  assign cid         = bus.rtr_out_pkt[D_W +: C_W];
  assign cid_ok      = 32'(cid) < CLUSTER_SIZE;
  assign unused_addr = ^bus.rtr_out_pkt[PKT_W-1:D_W+C_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pe_in_vld     <= '0;
      bus.pe_in_payload <= '0;
      drop_err          <= 1'b0;
    end else if (ce) begin
      bus.pe_in_vld <= (bus.rtr_out_v && cid_ok) ? (CLUSTER_SIZE'(1) << cid) : '0;
      if (bus.rtr_out_v) bus.pe_in_payload <= bus.rtr_out_pkt[D_W-1:0];
      if (bus.rtr_out_v && !cid_ok) drop_err <= 1'b1;
    end
  end
endmodule

// File: doc/cluster_inject_arbiter.md
Name: cluster_inject_arbiter

Overview:
- Shares one PS-router/Hoplite injection port among the CLUSTER_SIZE PEs of a cluster at grid tile (X,Y).
- PEs → router: round-robin arbitration feeding a single-entry holding register.
- Router → PEs: steers ejected packets to one PE by the packet's cluster-ID field.
- Sits between the PE array and ps_router in each tile. Replaces per-size ad-hoc cluster arbitration with one parameterised controller.

Parameters:
- CLUSTER_SIZE, 4, number of PEs sharing the port (1..16)
- D_W, 32, payload width
- X_W, 2, X address width
- Y_W, 2, Y address width
- C_W, 2, cluster-ID width; 2^C_W >= CLUSTER_SIZE
- PKT_W, D_W+C_W+Y_W+X_W, packet width; field order MSB→LSB is {X, Y, C, payload}
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; low freezes all state
- pe_req  in  CLUSTER_SIZE  per-PE packet-valid
- pe_pkt  in  CLUSTER_SIZE*PKT_W  flattened PE packets; PE k at [k*PKT_W +: PKT_W]
- pe_ack  out  CLUSTER_SIZE  one-hot, combinational; PE packet accepted this cycle
- pe_done  in  CLUSTER_SIZE  per-PE done flags
- rtr_vld  out  1  packet offered to router
- rtr_pkt  out  PKT_W  packet to router
- rtr_ack  in  1  router accepted rtr_pkt this cycle (only meaningful while rtr_vld=1)
- rtr_out_v  in  1  router ejection valid
- rtr_out_pkt  in  PKT_W  router ejected packet
- pe_in_vld  out  CLUSTER_SIZE  one-hot delivery valid, registered
- pe_in_payload  out  D_W  delivered payload, registered, shared by all PEs
- inj_count  out  CNT_W  packets injected to router, saturating
- drop_err  out  1  sticky: ejected packet had cluster ID >= CLUSTER_SIZE
- done  out  1  all PEs done and holding register empty

Behaviour:
- Reset values: hold_v=0, hold_pkt=0, rr_ptr=0, pe_in_vld=0, pe_in_payload=0, inj_count=0, drop_err=0.
- Reset is honoured mid-operation. A held packet is discarded and no ack is issued in the reset cycle.
- State is the holding register: EMPTY (hold_v=0) or FULL (hold_v=1).
- space = ce & (!hold_v | rtr_ack).
- Grant selection: the first k with pe_req[k]=1, searching k = rr_ptr, rr_ptr+1, … modulo CLUSTER_SIZE.
- When space is 1 and a grant exists:
  - pe_ack[g]=1 in the same cycle.
  - hold_pkt <= pe_pkt[g] and hold_v <= 1.
  - rr_ptr <= (g+1) mod CLUSTER_SIZE.
- If there is no space or no requester, pe_ack=0 and rr_ptr is unchanged.
- FULL with rtr_ack=1 and no new grant: hold_v <= 0.
- FULL with rtr_ack=1 and a new grant in the same cycle: the register reloads back-to-back. Sustained throughput is 1 packet/cycle.
- rtr_vld=hold_v and rtr_pkt=hold_pkt, both driven directly from registers.
- Injection latency: a PE acked in cycle t appears on rtr_vld in cycle t+1.
- A request that is not acked must be held stable by the PE. The arbiter never acks a PE whose pe_req=0.
- inj_count increments on each rtr_ack with hold_v=1 and saturates at all-ones.
- Ejection, when ce=1, with cid = rtr_out_pkt[D_W +: C_W]:
  - pe_in_vld <= rtr_out_v & (cid < CLUSTER_SIZE) ? onehot(cid) : 0.
  - pe_in_payload <= rtr_out_pkt[D_W-1:0] when rtr_out_v=1; otherwise it holds.
  - Delivery latency is 1 cycle. Ejection is never back-pressured.
- rtr_out_v=1 with cid >= CLUSTER_SIZE: the packet is dropped and drop_err <= 1. drop_err stays set until reset.
- Injection and ejection are independent and may occur in the same cycle.
- ce=0: no state change, pe_ack=0, outputs hold. rtr_ack and rtr_out_v are ignored while ce=0.
- done = &pe_done & !hold_v, combinational.
- CLUSTER_SIZE=1: rr_ptr is constant 0 and the arbiter degenerates to a 1-deep pipeline register.

Test Plan:
- Reset, then CLUSTER_SIZE=4 with pe_req=4'b1111 held and rtr_ack=1 constant → grants 0,1,2,3,0,… on consecutive cycles; rtr_vld continuous from cycle 2; inj_count=8 after 8 acked cycles.
- pe_req=4'b1010, rr_ptr=2, rtr_ack=0 → cycle 0: pe_ack=4'b1000 and hold filled. Following cycles: pe_ack=0, rtr_vld=1 stable, rtr_pkt equals PE3's packet. rtr_ack pulse → PE1 acked the same cycle and hold reloads.
- rtr_out_v=1 with cid=2, payload 0xDEADBEEF → next cycle pe_in_vld=4'b0100 and pe_in_payload=0xDEADBEEF. Then cid=5 with C_W=3 → pe_in_vld=0 and drop_err=1.
- Assert rst while hold_v=1 and pe_req=4'b0001 → rtr_vld=0 immediately, pe_ack=0 during reset; after release, PE0 is re-granted first.
- ce=0 for 5 cycles with requests and rtr_ack pending → no pe_ack, hold and inj_count unchanged. ce=1 → operation resumes where it left off.
- pe_done=4'b1111 with hold_v=1 → done=0; after rtr_ack → done=1 next cycle.
